// File: rtl/usb_rx_dec_pkg.sv
// Shared constants and types for the USB receive packet decoder.
// Control codes, PID values, status bit indices and FSM states.
package usb_rx_dec_pkg;

  localparam logic [7:0] CTRL_DATA_START  = 8'h00;
  localparam logic [7:0] CTRL_DATA_STREAM = 8'h01;
  localparam logic [7:0] CTRL_DATA_STOP   = 8'h02;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SOF   = 4'h5;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_DATA2 = 4'h7;
  localparam logic [3:0] PID_MDATA = 4'hF;

  localparam int ST_CRC   = 0;
  localparam int ST_STUFF = 1;
  localparam int ST_PID   = 2;
  localparam int ST_LEN   = 3;
  localparam int ST_ABORT = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PID,
    S_TOKEN1,
    S_TOKEN2,
    S_DATA,
    S_DISCARD,
    S_REPORT
  } state_e;

  typedef enum logic [1:0] {
    PC_TOKEN,
    PC_SOF,
    PC_DATA,
    PC_OTHER
  } pid_cls_e;

endpackage

// File: rtl/usb_rx_pid_check.sv
// PID byte complement check and packet type classification.
// SOF is only classed as a token-like packet under USB_RX_DEC_SOF_EN.
module usb_rx_pid_check
  import usb_rx_dec_pkg::*;
(
  input  logic [7:0] pid_byte_i,
  output logic       pid_ok_o,
  output pid_cls_e   pid_cls_o
);

  assign pid_ok_o = (pid_byte_i[7:4] == ~pid_byte_i[3:0]);

  // Map the PID nibble to the branch the decoder FSM takes
  always_comb begin
    pid_cls_o = PC_OTHER;
    unique case (pid_byte_i[3:0])
      PID_OUT, PID_IN, PID_SETUP: pid_cls_o = PC_TOKEN;
`ifdef USB_RX_DEC_SOF_EN
      PID_SOF: pid_cls_o = PC_SOF;
`endif
      PID_DATA0, PID_DATA1,
      PID_DATA2, PID_MDATA: pid_cls_o = PC_DATA;
      default: pid_cls_o = PC_OTHER;
    endcase
  end

endmodule

// File: rtl/usb_rx_packet_decoder.sv
// USB receive packet decoder: tokens, SOF, data payload, status report.
// Optional SOF frame-number decode enabled by USB_RX_DEC_SOF_EN.
module usb_rx_packet_decoder
  import usb_rx_dec_pkg::*;
#(
  parameter int MAX_PAYLOAD   = 1023,
  parameter int PAYLOAD_LEN_W = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               RxDataIn,
  input  logic [7:0]               RxCtrlIn,
  input  logic                     RxDataInWEn,
  input  logic [6:0]               devAddr,
  output logic                     pktValid,
  output logic [3:0]               pktPID,
  output logic [7:0]               pktStatus,
  output logic [6:0]               tokenAddr,
  output logic [3:0]               tokenEndp,
  output logic                     tokenMatch,
  output logic [10:0]              frameNum,
  output logic [7:0]               dataOut,
  output logic                     dataOutWEn,
  output logic [PAYLOAD_LEN_W-1:0] payloadLen
);

  localparam logic [PAYLOAD_LEN_W-1:0] MAXP =
    PAYLOAD_LEN_W'(MAX_PAYLOAD);
  localparam logic [PAYLOAD_LEN_W-1:0] SATP = '1;

  state_e state_q, state_d, cur;
  logic   restart_q, restart_d;
  logic [4:0] flg_q, flg_d;
  logic   tok_q, tok_d;
  logic   sof_q, sof_d;
  logic   dat_q, dat_d;
  logic [1:0] hold_q, hold_d;
  logic [7:0] h0_q, h0_d;
  logic [7:0] h1_q, h1_d;
  logic [7:0] b1_q, b1_d;
  logic [3:0] pid_q, pid_d;
  logic [PAYLOAD_LEN_W-1:0] pay_q, pay_d;

  logic [3:0] pout_q, pout_d;
  logic [4:0] stat_q, stat_d;
  logic [6:0] taddr_q, taddr_d;
  logic [3:0] tendp_q, tendp_d;
  logic       tmatch_q, tmatch_d;
  logic [PAYLOAD_LEN_W-1:0] len_q, len_d;
  logic [7:0] dout_q, dout_d;
  logic       dwen_q, dwen_d;
`ifdef USB_RX_DEC_SOF_EN
  logic [10:0] frame_q, frame_d;
`endif

  logic     pid_ok;
  pid_cls_e pid_cls;
  logic     is_start, is_stream, is_stop;

  usb_rx_pid_check u_pid_check (
    .pid_byte_i (RxDataIn),
    .pid_ok_o   (pid_ok),
    .pid_cls_o  (pid_cls)
  );

  assign is_start  = (RxCtrlIn == CTRL_DATA_START);
  assign is_stream = (RxCtrlIn == CTRL_DATA_STREAM);
  assign is_stop   = (RxCtrlIn == CTRL_DATA_STOP);

  // Next-state, packet bookkeeping and report capture
  always_comb begin
    state_d   = state_q;
    restart_d = restart_q;
    flg_d     = flg_q;
    tok_d     = tok_q;
    sof_d     = sof_q;
    dat_d     = dat_q;
    hold_d    = hold_q;
    h0_d      = h0_q;
    h1_d      = h1_q;
    b1_d      = b1_q;
    pid_d     = pid_q;
    pay_d     = pay_q;
    pout_d    = pout_q;
    stat_d    = stat_q;
    taddr_d   = taddr_q;
    tendp_d   = tendp_q;
    tmatch_d  = tmatch_q;
    len_d     = len_q;
    dout_d    = dout_q;
    dwen_d    = 1'b0;
`ifdef USB_RX_DEC_SOF_EN
    frame_d   = frame_q;
`endif
    cur = state_q;

    // REPORT behaves as IDLE, or as PID after an abort, for the new strobe
    if (state_q == S_REPORT) begin
      cur       = restart_q ? S_PID : S_IDLE;
      state_d   = cur;
      restart_d = 1'b0;
      flg_d     = '0;
      tok_d     = 1'b0;
      sof_d     = 1'b0;
      dat_d     = 1'b0;
      hold_d    = '0;
      pay_d     = '0;
    end

    if (RxDataInWEn) begin
      if (is_start) begin
        if (cur == S_IDLE) begin
          state_d = S_PID;
          flg_d   = '0;
          tok_d   = 1'b0;
          sof_d   = 1'b0;
          dat_d   = 1'b0;
          hold_d  = '0;
          pay_d   = '0;
        end else begin
          flg_d[ST_ABORT] = 1'b1;
          restart_d       = 1'b1;
          state_d         = S_REPORT;
        end
      end else if (is_stop) begin
        if (cur != S_IDLE) begin
          flg_d[ST_CRC]   = flg_d[ST_CRC] | RxDataIn[0];
          flg_d[ST_STUFF] = flg_d[ST_STUFF] | RxDataIn[1];
          if (cur == S_TOKEN1 || cur == S_TOKEN2)
            flg_d[ST_LEN] = 1'b1;
          if (cur == S_DATA && hold_q != 2'd2)
            flg_d[ST_LEN] = 1'b1;
          state_d = S_REPORT;
        end
      end else if (is_stream) begin
        case (cur)
          S_PID: begin
            pid_d = RxDataIn[3:0];
            if (!pid_ok) begin
              flg_d[ST_PID] = 1'b1;
              state_d       = S_DISCARD;
            end else begin
              case (pid_cls)
                PC_TOKEN: begin
                  tok_d   = 1'b1;
                  state_d = S_TOKEN1;
                end
                PC_SOF: begin
                  tok_d   = 1'b1;
                  sof_d   = 1'b1;
                  state_d = S_TOKEN1;
                end
                PC_DATA: begin
                  dat_d   = 1'b1;
                  state_d = S_DATA;
                end
                default: state_d = S_DISCARD;
              endcase
            end
          end
          S_TOKEN1: begin
            b1_d    = RxDataIn;
            state_d = S_TOKEN2;
          end
          S_TOKEN2: begin
            if (!sof_q) begin
              taddr_d = b1_q[6:0];
              tendp_d = {RxDataIn[2:0], b1_q[7]};
            end
`ifdef USB_RX_DEC_SOF_EN
            if (sof_q)
              frame_d = {RxDataIn[2:0], b1_q};
`endif
            state_d = S_DISCARD;
          end
          S_DATA: begin
            if (hold_q != 2'd2) begin
              hold_d = hold_q + 2'd1;
              if (hold_q == 2'd0) h0_d = RxDataIn;
              else                h1_d = RxDataIn;
            end else begin
              if (pay_q != SATP)
                pay_d = pay_q + 1'b1;
              if (pay_q >= MAXP) begin
                flg_d[ST_LEN] = 1'b1;
              end else if (!flg_q[ST_LEN]) begin
                dwen_d = 1'b1;
                dout_d = h0_q;
              end
              h0_d = h1_q;
              h1_d = RxDataIn;
            end
          end
          S_DISCARD: begin
            if (tok_q)
              flg_d[ST_LEN] = 1'b1;
          end
          default: ;
        endcase
      end
    end

    if (state_d == S_REPORT) begin
      pout_d   = pid_d;
      stat_d   = flg_d;
      tmatch_d = (taddr_d == devAddr);
      if (dat_d)
        len_d = pay_d;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      restart_q <= 1'b0;
      flg_q     <= '0;
      tok_q     <= 1'b0;
      sof_q     <= 1'b0;
      dat_q     <= 1'b0;
      hold_q    <= '0;
      h0_q      <= '0;
      h1_q      <= '0;
      b1_q      <= '0;
      pid_q     <= '0;
      pay_q     <= '0;
      pout_q    <= '0;
      stat_q    <= '0;
      taddr_q   <= '0;
      tendp_q   <= '0;
      tmatch_q  <= 1'b0;
      len_q     <= '0;
      dout_q    <= '0;
      dwen_q    <= 1'b0;
`ifdef USB_RX_DEC_SOF_EN
      frame_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      restart_q <= restart_d;
      flg_q     <= flg_d;
      tok_q     <= tok_d;
      sof_q     <= sof_d;
      dat_q     <= dat_d;
      hold_q    <= hold_d;
      h0_q      <= h0_d;
      h1_q      <= h1_d;
      b1_q      <= b1_d;
      pid_q     <= pid_d;
      pay_q     <= pay_d;
      pout_q    <= pout_d;
      stat_q    <= stat_d;
      taddr_q   <= taddr_d;
      tendp_q   <= tendp_d;
      tmatch_q  <= tmatch_d;
      len_q     <= len_d;
      dout_q    <= dout_d;
      dwen_q    <= dwen_d;
`ifdef USB_RX_DEC_SOF_EN
      frame_q   <= frame_d;
`endif
    end
  end

  assign pktValid   = (state_q == S_REPORT);
  assign pktPID     = pout_q;
  assign pktStatus  = {3'b000, stat_q};
  assign tokenAddr  = taddr_q;
  assign tokenEndp  = tendp_q;
  assign tokenMatch = tmatch_q;
  assign dataOut    = dout_q;
  assign dataOutWEn = dwen_q;
  assign payloadLen = len_q;
`ifdef USB_RX_DEC_SOF_EN
  assign frameNum   = frame_q;
`else
  assign frameNum   = 11'd0;
`endif

endmodule

// File: tb/tb_usb_rx_packet_decoder.sv
// Randomized bench for usb_rx_packet_decoder against a packet-level model.
// Honors USB_RX_DEC_SOF_EN for the expected SOF behaviour.
module tb_usb_rx_packet_decoder;

  localparam int LW   = 11;
  localparam int MAXP = 1023;
`ifdef USB_RX_DEC_SOF_EN
  localparam bit SOF_EN = 1'b1;
`else
  localparam bit SOF_EN = 1'b0;
`endif
  localparam logic [7:0] C_START  = 8'h00;
  localparam logic [7:0] C_STREAM = 8'h01;
  localparam logic [7:0] C_STOP   = 8'h02;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    RxDataIn, RxCtrlIn;
  logic          RxDataInWEn;
  logic [6:0]    devAddr;
  logic          pktValid;
  logic [3:0]    pktPID;
  logic [7:0]    pktStatus;
  logic [6:0]    tokenAddr;
  logic [3:0]    tokenEndp;
  logic          tokenMatch;
  logic [10:0]   frameNum;
  logic [7:0]    dataOut;
  logic          dataOutWEn;
  logic [LW-1:0] payloadLen;

  int checks = 0;
  int failures = 0;
  int vcnt = 0;
  int exp_vcnt = 0;
  bit started = 1'b0;

  logic [7:0]    got_q[$];
  logic [7:0]    exp_q[$];
  logic [7:0]    body_q[$];
  logic [6:0]    m_addr;
  logic [3:0]    m_endp;
  logic [10:0]   m_frame;
  logic [LW-1:0] m_len;

  logic [3:0] tok_t [4] = '{4'h1, 4'h9, 4'hD, 4'h5};
  logic [3:0] dat_t [4] = '{4'h3, 4'hB, 4'h7, 4'hF};
  logic [3:0] oth_t [7] = '{4'h2, 4'hA, 4'hE, 4'h6, 4'hC, 4'h8, 4'h4};

  always #5 clk = ~clk;

  usb_rx_packet_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .RxDataIn    (RxDataIn),
    .RxCtrlIn    (RxCtrlIn),
    .RxDataInWEn (RxDataInWEn),
    .devAddr     (devAddr),
    .pktValid    (pktValid),
    .pktPID      (pktPID),
    .pktStatus   (pktStatus),
    .tokenAddr   (tokenAddr),
    .tokenEndp   (tokenEndp),
    .tokenMatch  (tokenMatch),
    .frameNum    (frameNum),
    .dataOut     (dataOut),
    .dataOutWEn  (dataOutWEn),
    .payloadLen  (payloadLen)
  );

  always @(negedge clk) begin
    if (pktValid) vcnt++;
    if (dataOutWEn) got_q.push_back(dataOut);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] ctrl, input logic [7:0] data);
    RxCtrlIn = ctrl;
    RxDataIn = data;
    RxDataInWEn = 1'b1;
    @(posedge clk); #1;
    RxDataInWEn = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ":valid"}, pktValid, 0);
    chk({tag, ":pid"}, pktPID, 0);
    chk({tag, ":status"}, pktStatus, 0);
    chk({tag, ":addr"}, tokenAddr, 0);
    chk({tag, ":endp"}, tokenEndp, 0);
    chk({tag, ":match"}, tokenMatch, 0);
    chk({tag, ":frame"}, frameNum, 0);
    chk({tag, ":dout"}, dataOut, 0);
    chk({tag, ":dwen"}, dataOutWEn, 0);
    chk({tag, ":len"}, payloadLen, 0);
  endtask

  task automatic check_report(input string tag, input logic [3:0] ep,
                              input logic [4:0] est);
    @(negedge clk); #1;
    chk({tag, ":valid"}, pktValid, 1);
    chk({tag, ":pid"}, pktPID, ep);
    chk({tag, ":status"}, pktStatus, {3'b000, est});
    chk({tag, ":addr"}, tokenAddr, m_addr);
    chk({tag, ":endp"}, tokenEndp, m_endp);
    chk({tag, ":match"}, tokenMatch, m_addr == devAddr);
    chk({tag, ":frame"}, frameNum, m_frame);
    chk({tag, ":len"}, payloadLen, m_len);
    chk({tag, ":nbytes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s:byte%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_vcnt++;
  endtask

  task automatic run_pkt(input logic [7:0] pid, input bit abort,
                         input logic [1:0] stopb, input bit gaps,
                         input string tag);
    int n, pay, emit;
    bit ok, is_tok, is_sof, is_dat;
    logic [3:0] p;
    logic [4:0] st;
    n = body_q.size();
    p = pid[3:0];
    ok = (pid[7:4] == ~pid[3:0]);
    is_sof = ok && SOF_EN && p == 4'h5;
    is_tok = ok && (p == 4'h1 || p == 4'h9 || p == 4'hD || is_sof);
    is_dat = ok && (p == 4'h3 || p == 4'hB || p == 4'h7 || p == 4'hF);
    st = 5'd0;
    exp_q.delete();
    if (!ok) st[2] = 1'b1;
    if (is_tok) begin
      if (n > 2 || (!abort && n < 2)) st[3] = 1'b1;
      if (n >= 2) begin
        if (is_sof) m_frame = {body_q[1][2:0], body_q[0]};
        else begin
          m_addr = body_q[0][6:0];
          m_endp = {body_q[1][2:0], body_q[0][7]};
        end
      end
    end
    if (is_dat) begin
      pay = (n > 2) ? n - 2 : 0;
      if (pay > MAXP || (!abort && n < 2)) st[3] = 1'b1;
      emit = (pay > MAXP) ? MAXP : pay;
      for (int i = 0; i < emit; i++) exp_q.push_back(body_q[i]);
      m_len = (pay > 2047) ? 11'd2047 : LW'(pay);
    end
    if (abort) st[4] = 1'b1;
    else st[1:0] = stopb;

    if (!started) begin
      if (gaps && $urandom_range(0, 3) == 0)
        drive($urandom_range(0, 1) ? C_STREAM : C_STOP, 8'($urandom));
      drive(C_START, 8'($urandom));
      if (gaps) idle($urandom_range(0, 1));
    end
    drive(C_STREAM, pid);
    foreach (body_q[i]) begin
      if (gaps) idle($urandom_range(0, 1));
      drive(C_STREAM, body_q[i]);
    end
    if (abort) begin
      drive(C_START, 8'($urandom));
      started = 1'b1;
    end else begin
      if (gaps) idle($urandom_range(0, 1));
      drive(C_STOP, {6'($urandom), stopb});
      started = 1'b0;
    end
    check_report(tag, p, st);
  endtask

  initial begin
    logic [3:0] p;
    logic [7:0] pid;
    int kind, n;
    bit ab;
    logic [1:0] sb;

    rst = 1'b0;
    RxDataIn = 8'h00;
    RxCtrlIn = 8'h00;
    RxDataInWEn = 1'b0;
    devAddr = 7'd0;
    m_addr = '0; m_endp = '0; m_frame = '0; m_len = '0;
    idle(3);
    check_zero("reset");
    rst = 1'b1;

    devAddr = 7'd5;
    body_q.delete();
    body_q.push_back(8'h85); body_q.push_back(8'h02);
    run_pkt(8'h69, 1'b0, 2'b00, 1'b0, "in_tok");
    chk("in_tok:addr5", tokenAddr, 7'd5);
    chk("in_tok:endp5", tokenEndp, 4'd5);
    chk("in_tok:match1", tokenMatch, 1'b1);

    body_q.delete();
    body_q.push_back(8'h11); body_q.push_back(8'h22);
    body_q.push_back(8'h33); body_q.push_back(8'hAA);
    body_q.push_back(8'hBB);
    run_pkt(8'hC3, 1'b0, 2'b00, 1'b0, "data0");
    chk("data0:len3", payloadLen, 3);

    body_q.delete();
    body_q.push_back(8'h12); body_q.push_back(8'h34);
    body_q.push_back(8'h56);
    run_pkt(8'hC4, 1'b0, 2'b00, 1'b0, "piderr");
    chk("piderr:st", pktStatus, 8'h04);

    body_q.delete();
    repeat (1026) body_q.push_back(8'($urandom));
    run_pkt(8'h4B, 1'b0, 2'b00, 1'b0, "ovf");
    chk("ovf:lenerr", pktStatus[3], 1'b1);

    body_q.delete();
    body_q.push_back(8'hA1); body_q.push_back(8'hA2);
    body_q.push_back(8'hA3);
    run_pkt(8'hC3, 1'b1, 2'b00, 1'b0, "abort");
    chk("abort:st", pktStatus, 8'h10);
    body_q.delete();
    repeat (5) body_q.push_back(8'($urandom));
    run_pkt(8'h4B, 1'b0, 2'b01, 1'b0, "resync");
    chk("resync:st", pktStatus, 8'h01);

    body_q.delete();
    body_q.push_back(8'h34); body_q.push_back(8'h05);
    run_pkt(8'hA5, 1'b0, 2'b00, 1'b0, "sof");
    chk("sof:frame", frameNum, SOF_EN ? 11'h534 : 11'h000);

    drive(C_START, 8'h00);
    drive(C_STREAM, 8'hC3);
    repeat (4) drive(C_STREAM, 8'($urandom));
    rst = 1'b0;
    @(negedge clk); #1;
    check_zero("midrst");
    idle(1);
    rst = 1'b1;
    m_addr = '0; m_endp = '0; m_frame = '0; m_len = '0;
    got_q.delete();

    devAddr = 7'h2A;
    body_q.delete();
    body_q.push_back(8'hAA); body_q.push_back(8'h03);
    run_pkt(8'hE1, 1'b0, 2'b10, 1'b0, "postrst");

    for (int k = 0; k < 150; k++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 2) begin
        p = tok_t[$urandom_range(0, 3)];
        n = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 4) : 2;
        pid = {~p, p};
      end else if (kind <= 6) begin
        p = dat_t[$urandom_range(0, 3)];
        n = $urandom_range(0, 20);
        pid = {~p, p};
      end else if (kind <= 8) begin
        p = oth_t[$urandom_range(0, 6)];
        n = $urandom_range(0, 2);
        pid = {~p, p};
      end else begin
        pid = 8'($urandom);
        if (pid[7:4] == ~pid[3:0]) pid[7] = ~pid[7];
        n = $urandom_range(0, 3);
      end
      body_q.delete();
      repeat (n) body_q.push_back(8'($urandom));
      if (kind <= 2 && n > 0 && $urandom_range(0, 1) == 1)
        devAddr = body_q[0][6:0];
      else
        devAddr = 7'($urandom);
      ab = ($urandom_range(0, 7) == 0);
      sb = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      run_pkt(pid, ab, sb, 1'b1, $sformatf("rnd%0d", k));
    end

    body_q.delete();
    body_q.push_back(8'h01); body_q.push_back(8'h02);
    body_q.push_back(8'h03);
    run_pkt(8'h3C ^ 8'hFF, 1'b0, 2'b00, 1'b1, "final");

    idle(3);
    chk("pulse_count", vcnt, exp_vcnt);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usb_rx_packet_decoder.md
USB_RX_PACKET_DECODER -- requirements
Module: usb_rx_packet_decoder

Interface
REQ-001 SHALL have parameter MAX_PAYLOAD, default 1023, maximum accepted data-packet payload in bytes.
REQ-002 SHALL have parameter PAYLOAD_LEN_W, default 11, width of the payload length counter.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 RxDataIn  in  8  byte from the SIE receive path.
REQ-006 RxCtrlIn  in  8  control code from the SIE receive path.
REQ-007 RxDataInWEn  in  1  one-cycle strobe qualifying RxDataIn/RxCtrlIn; no backpressure.
REQ-008 devAddr  in  7  address used for token filtering.
REQ-009 pktValid  out  1  one-cycle end-of-packet pulse.
REQ-010 pktPID  out  4  PID[3:0] of the last packet.
REQ-011 pktStatus  out  8  status flags: bit0 crcErr, bit1 bitStuffErr, bit2 pidErr, bit3 lengthErr, bit4 abort; bits 7:5 are 0.
REQ-012 tokenAddr / tokenEndp  out  7 / 4  fields of the last token packet.
REQ-013 tokenMatch  out  1  tokenAddr equals devAddr.
REQ-014 frameNum  out  11  frame number of the last SOF packet.
REQ-015 dataOut / dataOutWEn  out  8 / 1  payload byte stream, with no CRC bytes.
REQ-016 payloadLen  out  PAYLOAD_LEN_W  payload byte count of the last data packet.

Function
REQ-017 Control codes are DATA_START=8'h00, DATA_STREAM=8'h01 and DATA_STOP=8'h02; on DATA_STOP, RxDataIn[1:0] carries {bitStuffErr, crcErr}.
REQ-018 The FSM SHALL have states IDLE, PID, TOKEN1, TOKEN2, DATA, DISCARD and REPORT; DATA_START moves the FSM from IDLE to PID.
REQ-019 In PID, if RxDataIn[7:4] is not ~RxDataIn[3:0], the FSM SHALL set pidErr and go to DISCARD.
REQ-020 In PID, a valid PID SHALL select the next state by PID type:
- OUT, IN, SETUP or SOF: go to TOKEN1.
- DATA0, DATA1, DATA2 or MDATA: go to DATA.
- any other PID: go to DISCARD, with no error.
REQ-021 Token byte 1 gives addr = b[6:0] and endp[0] = b[7]; token byte 2 gives endp[3:1] = b[2:0]; the FSM then goes to DISCARD to await DATA_STOP.
REQ-022 For SOF, frameNum[7:0] = byte 1 and frameNum[10:8] = byte 2 [2:0]; tokenAddr/tokenEndp SHALL NOT change.
REQ-023 Any further stream byte after token byte 2, or DATA_STOP before token byte 2, SHALL set lengthErr.
REQ-024 DATA state: a 2-byte delay pipeline SHALL hold back the newest two bytes; the oldest byte leaves on dataOut with dataOutWEn one cycle after the third and each later stream byte is accepted.
- On DATA_STOP, the two held bytes (CRC16) SHALL be dropped.
REQ-025 If the payload exceeds MAX_PAYLOAD, or fewer than 2 bytes follow the PID, the block SHALL set lengthErr; once set, no further dataOut strobes are issued.
REQ-026 DATA_STOP in any non-IDLE state SHALL go to REPORT.
- REPORT then updates pktPID, pktStatus, payloadLen and tokenMatch.
- REPORT pulses pktValid for one cycle, then returns to IDLE.
REQ-027 Latency SHALL be exactly 1 cycle from the DATA_STOP strobe to pktValid.
REQ-028 DATA_START in any state other than IDLE SHALL first report the current packet with abort=1, then begin a new packet.
- Resync: a new PID byte arriving in the REPORT cycle is accepted.
REQ-029 Strobes received in IDLE that are not DATA_START SHALL be ignored.
REQ-030 Byte counters SHALL saturate and SHALL NOT wrap.

Reset
REQ-031 While rst is 0, every output SHALL be 0, the FSM SHALL be IDLE, the pipeline SHALL be empty, and any in-flight packet is lost without a pktValid pulse.
REQ-032 The first accepted strobe after reset release SHALL be the one sampled on the first rising edge of clk with rst=1.

Configuration
REQ-033 With macro USB_RX_DEC_SOF_EN defined, SOF packets SHALL be decoded as in REQ-022.
REQ-034 Without USB_RX_DEC_SOF_EN, frameNum SHALL be tied to 0 and SOF SHALL be treated as an "other" PID, with pktValid still pulsing.

Structure
REQ-035 Shared package usb_rx_dec_pkg SHALL hold:
- the control codes;
- the PID constants;
- the pktStatus bit indices;
- the FSM state enum.
REQ-036 One sub-module, usb_rx_pid_check, SHALL implement PID complement validation and type classification combinationally.

Verification
REQ-037 IN token START, 0x69, 0x85, 0x02 (addr 5, endp 5), STOP(0x00) with devAddr=5 -> pktValid; pktPID=9, tokenAddr=5, tokenEndp=5, tokenMatch=1, pktStatus=0.
REQ-038 DATA0 START, 0xC3, 0x11, 0x22, 0x33, CRC 0xAA, 0xBB, STOP(0x00) -> dataOut 0x11, 0x22, 0x33 only; payloadLen=3, pktStatus=0.
REQ-039 PID byte 0xC4 -> pktStatus=0x04 (pidErr) and no dataOut strobes.
REQ-040 DATA1 with 1024 payload bytes plus CRC -> 1023 dataOut strobes; pktStatus bit3 set.
REQ-041 Mid-DATA START -> pktValid with pktStatus=0x10 and the new packet decodes correctly; then STOP(0x01) -> crcErr=1.
REQ-042 SOF 0xA5, 0x34, 0x05 with USB_RX_DEC_SOF_EN -> frameNum=0x534; without the macro -> frameNum=0.
